gate_vector_sequencer: RTL
==========================

// Module: gate_vector_sequencer
// PURPOSE
//  Upstream stimulus stage for the a/b/c logic-gate block (AND/OR/NOT).
//  On start, steps a 3-bit input vector {a,b,c} through NUM_VECTORS patterns.
//  Each pattern is held for exactly HOLD_CYCLES clocks.
//  Pattern order is binary or Gray, selected by mode. Replaces hand-written per-vector delays.
// PARAMETERS
//  HOLD_CYCLES  20  clocks each vector is held; legal range >=1
//  NUM_VECTORS  8   vectors per run, idx 0..NUM_VECTORS-1; legal range 1..8
// PORTS
//  clk      in   1  single clock, all logic on rising edge
//  rst_n    in   1  synchronous, active-low reset
//  start    in   1  begin a run; sampled in IDLE only
//  stop     in   1  abort a run; sampled in IDLE and RUN
//  mode     in   1  0=binary order, 1=Gray order; latched when start is accepted
//  a        out  1  vector bit 2 (MSB), feeds gate block input a
//  b        out  1  vector bit 1, feeds gate block input b
//  c        out  1  vector bit 0 (LSB), feeds gate block input c
//  vec_idx  out  3  index of the vector currently driven
//  vec_valid out 1  high while a/b/c carry a sequence vector
//  busy     out  1  high in RUN
//  done     out  1  one-cycle pulse after the last vector completes normally
// BEHAVIOUR
//  Reset (rst_n=0 at an edge, any state, including mid-run):
//   - state=IDLE; a=b=c=0; vec_idx=0; vec_valid=busy=done=0; hold_cnt=0; mode_q=0.
//  All outputs are registered. Latency from start accepted to first vector = 1 clk.
//  States: IDLE, RUN, DONE.
//  IDLE:
//   - start=1 & stop=0 -> next edge RUN; vec_idx=0; {a,b,c}=pat(0); vec_valid=busy=1;
//     hold_cnt=0; mode_q=mode.
//   - start & stop together -> remain IDLE (stop wins).
//  RUN:
//   - stop=1 -> next edge IDLE; outputs go to reset values; done stays 0.
//     stop has priority over hold expiry.
//   - else if hold_cnt < HOLD_CYCLES-1 -> hold_cnt++.
//   - else if vec_idx < NUM_VECTORS-1 -> vec_idx++; {a,b,c}=pat(vec_idx+1); hold_cnt=0.
//   - else -> DONE; a=b=c=0; vec_valid=busy=0; done=1.
//   - start is ignored while in RUN.
//  DONE: lasts exactly 1 clk; then IDLE with done=0. start in DONE is ignored.
//  pat(i), 3-bit:
//   - binary: i.
//   - Gray: i ^ (i>>1).
//   - a=pat[2], b=pat[1], c=pat[0].
//  Each vector is stable for exactly HOLD_CYCLES clocks; vec_valid is high for
//   NUM_VECTORS*HOLD_CYCLES clocks with no gap.
//  Degenerate cases:
//   - HOLD_CYCLES=1: vector changes every clock.
//   - NUM_VECTORS=1: a single vector, then DONE.
//  hold_cnt width = max(1,$clog2(HOLD_CYCLES)); it never exceeds HOLD_CYCLES-1.
//   vec_idx never wraps.
// STRUCTURE
//  Package gate_seq_pkg:
//   - state encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 decodes to IDLE).
//   - MODE_BIN=1'b0, MODE_GRAY=1'b1.
//   - function gray3(idx).
//  One combinational sub-module, gate_seq_encode (idx, mode -> 3-bit pattern).
//  The FSM, hold timer and output registers stay in the top.
// TESTING (HOLD_CYCLES=4, NUM_VECTORS=8 unless noted; DUT drives the gate block)
//  1 Reset: rst_n=0 for 2 clk -> all outputs 0, busy=0.
//    Release with no start -> outputs stay idle for 10 clk.
//  2 Binary run: mode=0, start pulse ->
//    - abc sequence 000,001,...,111, each held 4 clk.
//    - vec_valid high for 32 clk.
//    - done pulses once, then abc=000.
//    - Gate outputs checked per vector: t0=a&b, t1=a|b, t2=~c.
//  3 Gray run: mode=1 ->
//    - abc sequence 000,001,011,010,110,111,101,100.
//    - Exactly one bit changes per step.
//    - Toggling mode mid-run has no effect.
//  4 Abort: stop at vec_idx=3, hold_cnt=1 ->
//    - next clk: IDLE, abc=000, vec_valid=0.
//    - done never asserts.
//    - start+stop together in IDLE -> stays IDLE.
//  5 Reset mid-run: rst_n=0 at vec_idx=5 -> next edge all reset values.
//    - start while busy is ignored (vec_idx is not restarted).
//  6 Params HOLD_CYCLES=1, NUM_VECTORS=1 -> abc=000 for 1 clk, then done=1 for 1 clk.

Source files
------------

// File: rtl/gate_vector_sequencer_pkg.sv
// Shared state encoding, mode values and pattern helper for the gate vector sequencer.
// Latency: n/a (types and a pure function only); backpressure: n/a.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  function automatic logic [2:0] gray3(input logic [2:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_encode.sv
// Maps a vector index to its 3-bit {a,b,c} pattern in binary or Gray order.
// Latency: combinational; backpressure: none.
module gate_seq_encode
  import gate_seq_pkg::*;
(
  input  logic [2:0] idx,
  input  logic       mode,
  output logic [2:0] pat
);

  always_comb begin
    pat = (mode == MODE_GRAY) ? gray3(idx) : idx;
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Steps {a,b,c} through NUM_VECTORS binary/Gray patterns, each held HOLD_CYCLES clocks.
// Latency: first vector 1 clk after start; no backpressure, stop aborts the run on the next edge.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 20,
  parameter int NUM_VECTORS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       vec_valid,
  output logic       busy,
  output logic       done
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST  = 3'(NUM_VECTORS - 1);

  state_t          state;
  logic [HC_W-1:0] hold_cnt;
  logic            mode_q;
  logic [2:0]      abc_q;

  logic [2:0] enc_idx;
  logic       enc_mode;
  logic [2:0] enc_pat;

  // One encoder serves both the first vector (live mode) and each advance (latched mode).
  always_comb begin
    enc_idx  = 3'd0;
    enc_mode = mode;
    if (state == ST_RUN) begin
      enc_idx  = vec_idx + 3'd1;
      enc_mode = mode_q;
    end
  end

  gate_seq_encode u_encode (
    .idx  (enc_idx),
    .mode (enc_mode),
    .pat  (enc_pat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      mode_q    <= MODE_BIN;
      abc_q     <= 3'd0;
      vec_idx   <= 3'd0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (stop) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            abc_q     <= 3'd0;
            vec_idx   <= 3'd0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (hold_cnt < HOLD_LAST) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end else if (vec_idx < IDX_LAST) begin
            vec_idx  <= vec_idx + 3'd1;
            abc_q    <= enc_pat;
            hold_cnt <= '0;
          end else begin
            state     <= ST_DONE;
            hold_cnt  <= '0;
            abc_q     <= 3'd0;
            vec_idx   <= 3'd0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          // Idle, and the unused encoding 2'd3 recovers here.
          state <= ST_IDLE;
          if (start && !stop) begin
            state     <= ST_RUN;
            hold_cnt  <= '0;
            mode_q    <= mode;
            abc_q     <= enc_pat;
            vec_idx   <= 3'd0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
      endcase
    end
  end

  assign a = abc_q[2];
  assign b = abc_q[1];
  assign c = abc_q[0];

endmodule
